// File: rtl/hpdmc_rd_capture.sv
`timescale 1ns/1ps
// hpdmc_rd_capture: opens a CAS-latency capture window per READ and packs {dq_r, dq_f} into a FWFT FIFO.
// Optional macro HPDMC_RD_CAPTURE_PIPE_EN registers the captured word once before the FIFO write port.
module hpdmc_rd_capture #(
    parameter int DQ_WIDTH     = 16,
    parameter int BURST_CYCLES = 4,
    parameter int MAX_LAT      = 7,
    parameter int LAT_W        = 3,
    parameter int FIFO_AW      = 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  read_issue,
    input  logic [LAT_W-1:0]      rd_lat,
    input  logic [DQ_WIDTH-1:0]   dq_r,
    input  logic [DQ_WIDTH-1:0]   dq_f,
    output logic [2*DQ_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    output logic                  collision,
    input  logic                  err_clr
);
    localparam int WIN_W  = MAX_LAT + BURST_CYCLES;
    localparam int WORD_W = 2 * DQ_WIDTH;
    localparam int DEPTH  = 1 << FIFO_AW;

    function automatic int clamp_lat(input logic [LAT_W-1:0] lat);
        int v;
        v = {{(32-LAT_W){1'b0}}, lat};
        if (v < 1)       v = 1;
        if (v > MAX_LAT) v = MAX_LAT;
        return v;
    endfunction

    logic [WIN_W-1:0] win, lst;
    logic [WIN_W-1:0] win_shift, lst_shift, set_win, set_lst;
    logic             collide;
    int               lat_c;

    always_comb begin
        lat_c     = clamp_lat(rd_lat);
        win_shift = win >> 1;
        lst_shift = lst >> 1;
        set_win   = '0;
        set_lst   = '0;
        if (read_issue) begin
            for (int i = 0; i < WIN_W; i++) begin
                if (i >= lat_c - 1 && i <= lat_c + BURST_CYCLES - 2) set_win[i] = 1'b1;
                if (i == lat_c + BURST_CYCLES - 2)                   set_lst[i] = 1'b1;
            end
        end
        collide = |(win_shift & set_win);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win <= '0;
            lst <= '0;
        end else begin
            win <= win_shift | set_win;
            lst <= lst_shift | set_lst;
        end
    end

    logic              wr_req, wr_last;
    logic [WORD_W-1:0] wr_data;

`ifdef HPDMC_RD_CAPTURE_PIPE_EN
    // Stage p0: pins sampled at the window edge, FIFO written one cycle later
    logic              vld_p0, last_p0;
    logic [WORD_W-1:0] data_p0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= win[0];
            last_p0 <= lst[0];
        end
    end

    always_ff @(posedge sys_clk) begin
        data_p0 <= {dq_r, dq_f};
    end

    assign wr_req  = vld_p0;
    assign wr_last = last_p0;
    assign wr_data = data_p0;
`else
    assign wr_req  = win[0];
    assign wr_last = lst[0];
    assign wr_data = {dq_r, dq_f};
`endif

    // FIFO: extra pointer MSB distinguishes full from empty
    logic [WORD_W:0]  mem [DEPTH];
    logic [FIFO_AW:0] wptr, rptr;
    logic             empty, full, rd_en, wr_en, drop;
    logic [WORD_W:0]  head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
    assign rd_en = out_valid && out_ready;
    assign wr_en = wr_req && (!full || rd_en);
    assign drop  = wr_req && full && !rd_en;

    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wptr[FIFO_AW-1:0]] <= {wr_last, wr_data};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            overflow  <= drop    | (overflow  & ~err_clr);
            collision <= collide | (collision & ~err_clr);
        end
    end

    assign head       = mem[rptr[FIFO_AW-1:0]];
    assign out_valid  = !empty;
    assign out_data   = out_valid ? head[WORD_W-1:0] : '0;
    assign out_last   = out_valid & head[WORD_W];
    assign fifo_level = wptr - rptr;

endmodule

// File: tb/tb_hpdmc_rd_capture.sv
`timescale 1ns/1ps
// Directed bench for hpdmc_rd_capture; PD tracks the extra write latency of the pipelined build.
module tb_hpdmc_rd_capture;
`ifdef HPDMC_RD_CAPTURE_PIPE_EN
    localparam int PD = 1;
`else
    localparam int PD = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        read_issue = 1'b0;
    logic [2:0]  rd_lat = 3'd0;
    logic [15:0] dq_r = 16'h0;
    logic [15:0] dq_f = 16'h0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] out_data;
    logic        out_valid, out_last, overflow, collision;
    logic [3:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    hpdmc_rd_capture #(
        .DQ_WIDTH(16), .BURST_CYCLES(4), .MAX_LAT(7), .LAT_W(3), .FIFO_AW(3)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .read_issue(read_issue), .rd_lat(rd_lat),
        .dq_r(dq_r), .dq_f(dq_f), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .fifo_level(fifo_level),
        .overflow(overflow), .collision(collision), .err_clr(err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // Drive one cycle of inputs, pass one rising edge, return 1ns after it.
    task automatic cyc(input logic iss, input logic [2:0] lat, input logic [15:0] r, input logic [15:0] f);
        read_issue = iss;
        rd_lat     = lat;
        dq_r       = r;
        dq_f       = f;
        @(posedge sys_clk);
        #1;
        read_issue = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd1, 16'h0, 16'h0);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle(2);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_tests++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_tests++; if ({overflow, collision, out_last} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {overflow, collision, out_last}); end
        sys_rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_single_read();
        logic [31:0] exp;
        out_ready = 1'b0;
        cyc(1'b1, 3'd3, 16'h0, 16'h0);
        for (int n = 1; n <= 8; n++) begin
            if (n >= 3 && n <= 6) cyc(1'b0, 3'd3, 16'(2*(n-3)+1), 16'(2*(n-3)+2));
            else                  cyc(1'b0, 3'd3, 16'hdead, 16'hbeef);
            if (n == 2+PD) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
            end
            if (n == 3+PD) begin
                n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_first_valid: got %b want 1", out_valid); end
                n_tests++; if (out_data !== 32'h00010002) begin n_fail++; $display("FAIL single_first_data: got %h want 00010002", out_data); end
                n_tests++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single_first_level: got %0d want 1", fifo_level); end
            end
        end
        n_tests++; if (fifo_level !== 4'd4) begin n_fail++; $display("FAIL single_peak_level: got %0d want 4", fifo_level); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = {16'(2*k+1), 16'(2*k+2)};
            n_tests++; if (out_data !== exp) begin n_fail++; $display("FAIL single_word%0d: got %h want %h", k, out_data, exp); end
            n_tests++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL single_last%0d: got %b want %b", k, out_last, (k == 3)); end
            idle(1);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL single_drained: valid %b level %0d want 0 0", out_valid, fifo_level); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        out_ready = 1'b0;
        cyc(1'b1, 3'd2, 16'h0, 16'h0);
        for (int n = 1; n <= 11; n++) begin
            cyc(n == 4, 3'd2, 16'(n), 16'(n) + 16'h0100);
            if (n >= 2+PD && n <= 9+PD) begin
                n_tests++; if (fifo_level !== 4'(n-1-PD)) begin n_fail++; $display("FAIL b2b_level_e%0d: got %0d want %0d", n, fifo_level, n-1-PD); end
            end
        end
        n_tests++; if (collision !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: coll %b ovf %b want 0 0", collision, overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = {16'(k+2), 16'(k+2) + 16'h0100};
            n_tests++; if (out_data !== exp || out_last !== (k == 3 || k == 7)) begin
                n_fail++; $display("FAIL b2b_word%0d: got %h/%b want %h/%b", k, out_data, out_last, exp, (k == 3 || k == 7));
            end
            idle(1);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_collision();
        int got;
        int m;
        logic [31:0] exp;
        got = 0;
        out_ready = 1'b1;
        cyc(1'b1, 3'd2, 16'h0, 16'h0);
        for (int n = 1; n <= 16; n++) begin
            cyc(n == 4 || n == 6, 3'd2, 16'(n), 16'(n) ^ 16'hffff);
            if (n == 5) begin
                n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_before: got %b want 0", collision); end
            end
            if (n == 6) begin
                n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_set: got %b want 1", collision); end
            end
            if (out_valid === 1'b1) begin
                m   = got + 2;
                exp = {16'(m), 16'(m) ^ 16'hffff};
                n_tests++; if (out_data !== exp || out_last !== (m == 5 || m == 9 || m == 11)) begin
                    n_fail++; $display("FAIL coll_word%0d: got %h/%b want %h/%b", got, out_data, out_last, exp, (m == 5 || m == 9 || m == 11));
                end
                got++;
            end
        end
        n_tests++; if (got != 10) begin n_fail++; $display("FAIL coll_count: got %0d want 10", got); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL coll_overflow: got %b want 0", overflow); end
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_clear: got %b want 0", collision); end
        out_ready = 1'b0;
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        for (int n = 0; n <= 5; n++) begin
            cyc(n == 0, 3'd0, 16'h1111, 16'h2222);
            if (n == PD) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat0_early: got %b want 0", out_valid); end
            end
            if (n == 1+PD) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h11112222) begin n_fail++; $display("FAIL lat0_first: got %b/%h want 1/11112222", out_valid, out_data); end
            end
        end
        out_ready = 1'b1;
        idle(6);
        out_ready = 1'b0;
        for (int n = 0; n <= 12; n++) begin
            cyc(n == 0, 3'd7, 16'h3333, 16'h4444);
            if (n == 6+PD) begin
                n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat7_early: got %b want 0", out_valid); end
            end
            if (n == 7+PD) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h33334444) begin n_fail++; $display("FAIL lat7_first: got %b/%h want 1/33334444", out_valid, out_data); end
            end
        end
        out_ready = 1'b1;
        idle(6);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        out_ready = 1'b0;
        for (int n = 0; n <= 14; n++) begin
            cyc(n == 0 || n == 4 || n == 8, 3'd1, 16'(n), 16'(n) + 16'h0200);
            if (n == 8+PD) begin
                n_tests++; if (fifo_level !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_full: level %0d ovf %b want 8 0", fifo_level, overflow); end
            end
            if (n == 9+PD) begin
                n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
            end
        end
        n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp = {16'(k+1), 16'(k+1) + 16'h0200};
            n_tests++; if (out_data !== exp || out_last !== (k == 3 || k == 7)) begin
                n_fail++; $display("FAIL ovf_word%0d: got %h/%b want %h/%b", k, out_data, out_last, exp, (k == 3 || k == 7));
            end
            idle(1);
        end
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: valid %b ovf %b want 0 1", out_valid, overflow); end
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end

        for (int n = 0; n <= 16; n++) begin
            out_ready = (n >= 9+PD);
            cyc(n == 0 || n == 4 || n == 8, 3'd1, 16'(n), 16'(n) + 16'h0200);
            if (n == 8+PD) begin
                n_tests++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_rw_pre: got %0d want 8", fifo_level); end
            end
            if (n == 9+PD) begin
                n_tests++; if (fifo_level !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_level: level %0d ovf %b want 8 0", fifo_level, overflow); end
                n_tests++; if (out_data !== 32'h00020202) begin n_fail++; $display("FAIL full_rw_head: got %h want 00020202", out_data); end
            end
        end
        idle(8);
        out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_end: valid %b ovf %b want 0 0", out_valid, overflow); end
    endtask

    task automatic test_reset_mid_burst();
        out_ready = 1'b0;
        cyc(1'b1, 3'd2, 16'h00aa, 16'h00bb);
        cyc(1'b1, 3'd2, 16'h00aa, 16'h00bb);
        cyc(1'b0, 3'd2, 16'h00aa, 16'h00bb);
        cyc(1'b0, 3'd2, 16'h00aa, 16'h00bb);
        n_tests++; if (out_valid !== 1'b1 || collision !== 1'b1) begin n_fail++; $display("FAIL rst_pre: valid %b coll %b want 1 1", out_valid, collision); end
        sys_rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL rst_async_out: %b/%b/%h want 0/0/0", out_valid, out_last, out_data); end
        n_tests++; if (fifo_level !== 4'd0 || collision !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_async_state: level %0d coll %b ovf %b want 0", fifo_level, collision, overflow); end
        idle(2);
        sys_rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, 3'd2, 16'hffff, 16'hffff);
            n_tests++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_no_capture_%0d: valid %b level %0d want 0 0", n, out_valid, fifo_level); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_collision();
        test_latency();
        test_overflow();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
